// File: rtl/parking_pkg.sv
// Shared definitions for the car-park entry controller.
//   state_t       : controller state encoding
//   SEG_*         : active-low 7-segment glyphs, bit order {g,f,e,d,c,b,a}
//   PASS*_DEFAULT : factory password digits
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    WAIT_PASSWORD = 3'd1,
    WRONG_PASS    = 3'd2,
    RIGHT_PASS    = 3'd3,
    STOP          = 3'd4
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_N     = 7'b0101011;
  localparam logic [6:0] SEG_G     = 7'b0000010;
  localparam logic [6:0] SEG_O     = 7'b1000000;
  localparam logic [6:0] SEG_S     = 7'b0010010;
  localparam logic [6:0] SEG_P     = 7'b0001100;

  localparam logic [1:0] PASS1_DEFAULT = 2'b01;
  localparam logic [1:0] PASS2_DEFAULT = 2'b10;

endpackage

// File: rtl/parking_seg_decode.sv
// Combinational state-to-display lookup for the two gate digits.
// Ports:
//   state : current controller state
//   hex_1 : left digit, active-low segments {g,f,e,d,c,b,a}
//   hex_2 : right digit, same encoding
module parking_seg_decode
  import parking_pkg::*;
(
  input  state_t     state,
  output logic [6:0] hex_1,
  output logic [6:0] hex_2
);

  always_comb begin
    hex_1 = SEG_BLANK;
    hex_2 = SEG_BLANK;
    case (state)
      WAIT_PASSWORD: begin hex_1 = SEG_E; hex_2 = SEG_N; end
      WRONG_PASS:    begin hex_1 = SEG_E; hex_2 = SEG_E; end
      RIGHT_PASS:    begin hex_1 = SEG_G; hex_2 = SEG_O; end
      STOP:          begin hex_1 = SEG_S; hex_2 = SEG_P; end
      default:       begin hex_1 = SEG_BLANK; hex_2 = SEG_BLANK; end
    endcase
  end

endmodule

// File: rtl/parking_system_ctrl.sv
// Password-gated car-park entry controller.
// A car at the entrance opens a WAIT_CYCLES-long password window; the
// password decides between "GO" (green) and "EE" (red). A second car at
// the entrance while the gate is open forces "SP" until the password is
// re-entered.
// Ports:
//   clk             : system clock, rising edge
//   reset_n         : asynchronous reset, ACTIVE-HIGH despite the name
//   sensor_entrance : car present at entrance
//   sensor_exit     : car present at exit
//   password_1/2    : 2-bit password digits
//   GREEN_LED       : gate-open indicator (registered)
//   RED_LED         : gate-closed/error indicator (registered)
//   HEX_1/HEX_2     : active-low 7-segment digits {g,f,e,d,c,b,a} (registered)
// Build option:
//   PARKING_LED_BLINK_EN : when defined the active LED toggles every cycle
//                          in WRONG_PASS/RIGHT_PASS/STOP; otherwise it is
//                          held steady at 1.
module parking_system_ctrl
  import parking_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 4,
  parameter logic [1:0]  PASS1       = PASS1_DEFAULT,
  parameter logic [1:0]  PASS2       = PASS2_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sensor_entrance,
  input  logic       sensor_exit,
  input  logic [1:0] password_1,
  input  logic [1:0] password_2,
  output logic       GREEN_LED,
  output logic       RED_LED,
  output logic [6:0] HEX_1,
  output logic [6:0] HEX_2
);

  localparam int unsigned CW = $clog2(WAIT_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          pass_ok;
  logic          green_nxt;
  logic          red_nxt;
  logic          blink_green;
  logic          blink_red;
  logic [6:0]    hex_1_nxt;
  logic [6:0]    hex_2_nxt;

  always_comb pass_ok = (password_1 == PASS1) && (password_2 == PASS2);

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:          state_nxt = sensor_entrance ? WAIT_PASSWORD : IDLE;
      WAIT_PASSWORD: begin
        if (wait_cnt == LAST) state_nxt = pass_ok ? RIGHT_PASS : WRONG_PASS;
        else                  state_nxt = WAIT_PASSWORD;
      end
      WRONG_PASS:    state_nxt = pass_ok ? RIGHT_PASS : WRONG_PASS;
      RIGHT_PASS: begin
        if (sensor_entrance && sensor_exit) state_nxt = STOP;
        else if (sensor_exit)               state_nxt = IDLE;
        else                                state_nxt = RIGHT_PASS;
      end
      STOP:          state_nxt = pass_ok ? RIGHT_PASS : STOP;
      default:       state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // Cleared outside WAIT_PASSWORD, so it always starts at 0 on entry.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      wait_cnt <= '0;
    end else if (state == WAIT_PASSWORD) begin
      if (wait_cnt != LAST) wait_cnt <= wait_cnt + CW'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

`ifdef PARKING_LED_BLINK_EN
  // shown_state is the state the outputs currently display; a mismatch
  // with state marks the first output cycle after entry, where the
  // blink phase restarts at 1.
  state_t shown_state;
  logic   entered;

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) shown_state <= IDLE;
    else         shown_state <= state;
  end

  always_comb begin
    entered     = (state != shown_state);
    blink_green = entered ? 1'b1 : ~GREEN_LED;
    blink_red   = entered ? 1'b1 : ~RED_LED;
  end
`else
  always_comb begin
    blink_green = 1'b1;
    blink_red   = 1'b1;
  end
`endif

  always_comb begin
    green_nxt = 1'b0;
    red_nxt   = 1'b0;
    case (state)
      WAIT_PASSWORD:    red_nxt   = 1'b1;
      WRONG_PASS, STOP: red_nxt   = blink_red;
      RIGHT_PASS:       green_nxt = blink_green;
      default: begin
        green_nxt = 1'b0;
        red_nxt   = 1'b0;
      end
    endcase
  end

  parking_seg_decode u_seg (
    .state (state),
    .hex_1 (hex_1_nxt),
    .hex_2 (hex_2_nxt)
  );

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      GREEN_LED <= 1'b0;
      RED_LED   <= 1'b0;
      HEX_1     <= SEG_BLANK;
      HEX_2     <= SEG_BLANK;
    end else begin
      GREEN_LED <= green_nxt;
      RED_LED   <= red_nxt;
      HEX_1     <= hex_1_nxt;
      HEX_2     <= hex_2_nxt;
    end
  end

endmodule

// File: tb/tb_parking_system_ctrl.sv
// Scoreboard bench for parking_system_ctrl (WAIT_CYCLES = 4).
// Each stimulus cycle pushes the outputs expected after the next rising
// edge; a monitor pops and compares one entry per edge.
module tb_parking_system_ctrl;

`ifdef PARKING_LED_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] GE = 7'b0000110;
  localparam logic [6:0] GN = 7'b0101011;
  localparam logic [6:0] GG = 7'b0000010;
  localparam logic [6:0] GO = 7'b1000000;
  localparam logic [6:0] GS = 7'b0010010;
  localparam logic [6:0] GP = 7'b0001100;

  typedef struct {
    logic       g;
    logic       r;
    logic [6:0] h1;
    logic [6:0] h2;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       sensor_entrance = 1'b0;
  logic       sensor_exit = 1'b0;
  logic [1:0] password_1 = 2'b00;
  logic [1:0] password_2 = 2'b00;
  logic       GREEN_LED;
  logic       RED_LED;
  logic [6:0] HEX_1;
  logic [6:0] HEX_2;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  parking_system_ctrl #(.WAIT_CYCLES(4)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .sensor_entrance (sensor_entrance),
    .sensor_exit     (sensor_exit),
    .password_1      (password_1),
    .password_2      (password_2),
    .GREEN_LED       (GREEN_LED),
    .RED_LED         (RED_LED),
    .HEX_1           (HEX_1),
    .HEX_2           (HEX_2)
  );

  always #5 clk = ~clk;

  function automatic logic blk(input logic ph);
    return BLINK ? ph : 1'b1;
  endfunction

  task automatic check(input exp_t e);
    checks++;
    if (GREEN_LED !== e.g || RED_LED !== e.r || HEX_1 !== e.h1 || HEX_2 !== e.h2) begin
      errors++;
      $display("FAIL %s: got G=%b R=%b H1=%b H2=%b, want G=%b R=%b H1=%b H2=%b",
               e.name, GREEN_LED, RED_LED, HEX_1, HEX_2, e.g, e.r, e.h1, e.h2);
    end
  endtask

  task automatic step(input logic se, input logic sx, input logic [1:0] p1,
                      input logic [1:0] p2, input logic g, input logic r,
                      input logic [6:0] h1, input logic [6:0] h2, input string nm);
    exp_t e;
    sensor_entrance = se;
    sensor_exit     = sx;
    password_1      = p1;
    password_2      = p2;
    e.g = g; e.r = r; e.h1 = h1; e.h2 = h2; e.name = nm;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check(e);
      end
    end
  end

  initial begin
    exp_t rst_e;
    rst_e.g = 1'b0; rst_e.r = 1'b0; rst_e.h1 = BL; rst_e.h2 = BL;

    #50;
    rst_e.name = "reset_hold";
    check(rst_e);
    #50;
    reset_n = 1'b0;
    @(posedge clk);
    #2;

    // Wrong password path
    step(1, 0, 0, 0, 0, 0,       BL, BL, "idle_out");
    step(0, 0, 0, 0, 0, 1,       GE, GN, "wait_c0");
    step(0, 0, 0, 0, 0, 1,       GE, GN, "wait_c1");
    step(0, 0, 0, 0, 0, 1,       GE, GN, "wait_c2");
    step(0, 0, 0, 0, 0, 1,       GE, GN, "wait_c3");
    step(0, 0, 0, 0, 0, blk(1),  GE, GE, "wrong_1");
    step(0, 0, 0, 0, 0, blk(0),  GE, GE, "wrong_2");
    step(0, 0, 1, 2, 0, blk(1),  GE, GE, "wrong_3_fix");
    // Correct password from WRONG_PASS, then normal exit
    step(0, 0, 1, 2, blk(1), 0,  GG, GO, "right_1");
    step(0, 0, 0, 0, blk(0), 0,  GG, GO, "right_2");
    step(0, 1, 0, 0, blk(1), 0,  GG, GO, "right_exit");
    step(0, 0, 0, 0, 0, 0,       BL, BL, "exit_idle");
    // Correct password during the window; sensors ignored while waiting
    step(1, 0, 1, 2, 0, 0,       BL, BL, "idle_out2");
    step(1, 1, 1, 2, 0, 1,       GE, GN, "wait2_c0");
    step(0, 0, 1, 2, 0, 1,       GE, GN, "wait2_c1");
    step(0, 0, 1, 2, 0, 1,       GE, GN, "wait2_c2");
    step(0, 0, 1, 2, 0, 1,       GE, GN, "wait2_c3");
    step(0, 0, 1, 2, blk(1), 0,  GG, GO, "direct_right");
    // Tailgate
    step(1, 1, 0, 0, blk(0), 0,  GG, GO, "right_tailgate");
    step(0, 0, 3, 3, 0, blk(1),  GS, GP, "stop_1");
    step(0, 0, 3, 3, 0, blk(0),  GS, GP, "stop_2");
    step(0, 0, 3, 3, 0, blk(1),  GS, GP, "stop_3");
    step(0, 0, 1, 2, 0, blk(0),  GS, GP, "stop_fix");
    step(0, 0, 0, 0, blk(1), 0,  GG, GO, "reright_1");
    step(0, 0, 0, 0, blk(0), 0,  GG, GO, "reright_2");
    step(1, 0, 0, 0, blk(1), 0,  GG, GO, "right_entr_only");
    step(0, 0, 0, 0, blk(0), 0,  GG, GO, "right_stays");

    // Asynchronous reset mid-RIGHT_PASS, between clock edges
    reset_n = 1'b1;
    #1;
    rst_e.name = "async_reset";
    check(rst_e);
    #2;
    reset_n = 1'b0;
    step(1, 0, 0, 0, 0, 0,       BL, BL, "post_rst_idle");
    step(0, 0, 0, 0, 0, 1,       GE, GN, "post_rst_wait");

    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending, want 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
